// File: rtl/crc16_rx_checker_if.sv
// ---------------------------------------------------------------------------
// crc16_rx_checker_if : serial bit stream in, packet status out.
// Optional byte port under CRC16_RX_BYTE_OUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface crc16_rx_checker_if;
   logic        din;
   logic        shiftEn;
   logic        sop;
   logic        eop;
   logic        busy;
   logic        done;
   logic        crc_ok;
   logic        crc_err;
   logic        err_short;
   logic        err_align;
   logic        err_ovf;
   logic [10:0] byte_count;
`ifdef CRC16_RX_BYTE_OUT_EN
   logic [7:0]  rx_byte;
   logic        rx_byte_valid;

   modport master (
      output din, shiftEn, sop, eop,
      input  busy, done, crc_ok, crc_err, err_short, err_align, err_ovf, byte_count,
      input  rx_byte, rx_byte_valid
   );
   modport slave (
      input  din, shiftEn, sop, eop,
      output busy, done, crc_ok, crc_err, err_short, err_align, err_ovf, byte_count,
      output rx_byte, rx_byte_valid
   );
`else
   modport master (
      output din, shiftEn, sop, eop,
      input  busy, done, crc_ok, crc_err, err_short, err_align, err_ovf, byte_count
   );
   modport slave (
      input  din, shiftEn, sop, eop,
      output busy, done, crc_ok, crc_err, err_short, err_align, err_ovf, byte_count
   );
`endif
endinterface

`default_nettype wire

// File: rtl/crc16_rx_checker.sv
// ---------------------------------------------------------------------------
// crc16_rx_checker : USB RX CRC16 residue checker with bit/byte accounting.
// Macro CRC16_RX_BYTE_OUT_EN adds the assembled-byte output.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module crc16_rx_checker #(
   parameter logic [15:0] INIT      = 16'hFFFF,
   parameter logic [15:0] RESIDUE   = 16'h800D,
   parameter int unsigned MAX_BYTES = 1026
) (
   input  wire logic           clk,
   input  wire logic           nRst,
   crc16_rx_checker_if.slave   if_rx
);

   localparam logic [11:0] c_MAX_BYTES = 12'(MAX_BYTES);
   localparam logic [10:0] c_BYTE_SAT  = 11'd2047;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RECV = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_lfsr;
   logic [2:0]  r_bit_cnt;
   logic [10:0] r_byte_cnt;
   logic        r_ovf;
   logic        r_done;
   logic        r_crc_ok;
   logic        r_crc_err;
   logic        r_err_short;
   logic        r_err_align;

   logic        w_start;
   logic        w_end;
   logic        w_shift;
   logic [15:0] w_lfsr_base;
   logic [15:0] w_lfsr_nxt;
   logic [2:0]  w_bit_base;
   logic [2:0]  w_bit_nxt;
   logic [10:0] w_byte_base;
   logic [10:0] w_byte_nxt;
   logic        w_ovf_nxt;
   logic        w_crc_err;
   logic        w_short;
   logic        w_align;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic b);
      logic f;
      f = b ^ s[15];
      return {s[14] ^ f, s[13:2], s[1] ^ f, s[0], f};
   endfunction

   // sop always wins; eop only matters while a packet is open
   assign w_start = if_rx.sop;
   assign w_end   = (r_state == ST_RECV) && if_rx.eop && !if_rx.sop;
   assign w_shift = if_rx.shiftEn && (if_rx.sop || (r_state == ST_RECV));

   assign w_lfsr_base = w_start ? INIT : r_lfsr;
   assign w_bit_base  = w_start ? 3'd0 : r_bit_cnt;
   assign w_byte_base = w_start ? 11'd0 : r_byte_cnt;

   assign w_lfsr_nxt  = w_shift ? lfsr_step(w_lfsr_base, if_rx.din) : w_lfsr_base;
   assign w_bit_nxt   = w_shift ? (w_bit_base + 3'd1) : w_bit_base;

   always_comb begin
      w_byte_nxt = w_byte_base;
      if (w_shift && (w_bit_base == 3'd7) && (w_byte_base != c_BYTE_SAT)) begin
         w_byte_nxt = w_byte_base + 11'd1;
      end
   end

   assign w_ovf_nxt = (w_start ? 1'b0 : r_ovf) | ({1'b0, w_byte_nxt} > c_MAX_BYTES);

   // Final-bit-inclusive verdicts, registered on the eop edge
   assign w_crc_err = (w_lfsr_nxt != RESIDUE);
   assign w_short   = (w_byte_nxt < 11'd2);
   assign w_align   = (w_bit_nxt != 3'd0);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (if_rx.sop) begin
               w_state_nxt = ST_RECV;
            end
         end
         ST_RECV: begin
            if (if_rx.sop) begin
               w_state_nxt = ST_RECV;
            end else if (if_rx.eop) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_lfsr      <= INIT;
         r_bit_cnt   <= 3'd0;
         r_byte_cnt  <= 11'd0;
         r_ovf       <= 1'b0;
         r_done      <= 1'b0;
         r_crc_ok    <= 1'b0;
         r_crc_err   <= 1'b0;
         r_err_short <= 1'b0;
         r_err_align <= 1'b0;
      end else begin
         r_lfsr     <= w_lfsr_nxt;
         r_bit_cnt  <= w_bit_nxt;
         r_byte_cnt <= w_byte_nxt;
         r_ovf      <= w_ovf_nxt;
         r_done     <= w_end;
         if (w_start) begin
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
            r_err_short <= 1'b0;
            r_err_align <= 1'b0;
         end else if (w_end) begin
            r_crc_ok    <= !w_crc_err && !w_short && !w_align && !w_ovf_nxt;
            r_crc_err   <= w_crc_err;
            r_err_short <= w_short;
            r_err_align <= w_align;
         end
      end
   end

   assign if_rx.busy       = (r_state == ST_RECV);
   assign if_rx.done       = r_done;
   assign if_rx.crc_ok     = r_crc_ok;
   assign if_rx.crc_err    = r_crc_err;
   assign if_rx.err_short  = r_err_short;
   assign if_rx.err_align  = r_err_align;
   assign if_rx.err_ovf    = r_ovf;
   assign if_rx.byte_count = r_byte_cnt;

`ifdef CRC16_RX_BYTE_OUT_EN
   logic [7:0] r_asm;
   logic [7:0] r_rx_byte;
   logic       r_rx_byte_valid;

   // LSB-first: each new bit enters at the top and slides down
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_asm           <= 8'd0;
         r_rx_byte       <= 8'd0;
         r_rx_byte_valid <= 1'b0;
      end else begin
         r_rx_byte_valid <= 1'b0;
         if (w_shift) begin
            r_asm <= {if_rx.din, r_asm[7:1]};
            if (w_bit_base == 3'd7) begin
               r_rx_byte       <= {if_rx.din, r_asm[7:1]};
               r_rx_byte_valid <= 1'b1;
            end
         end
      end
   end

   assign if_rx.rx_byte       = r_rx_byte;
   assign if_rx.rx_byte_valid = r_rx_byte_valid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc16_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_crc16_rx_checker : randomized packets against a polynomial CRC model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_crc16_rx_checker;

   typedef struct packed {
      logic [10:0] bytes;
      logic        ok;
      logic        err;
      logic        sh;
      logic        al;
      logic        ov;
   } exp_t;

   logic clk  = 1'b0;
   logic nRst = 1'b0;
   always #5 clk = ~clk;

   crc16_rx_checker_if bus ();
   crc16_rx_checker_if bus4 ();

   crc16_rx_checker dut (.clk(clk), .nRst(nRst), .if_rx(bus));
   crc16_rx_checker #(.MAX_BYTES(4)) dut4 (.clk(clk), .nRst(nRst), .if_rx(bus4));

   assign bus4.din     = bus.din;
   assign bus4.shiftEn = bus.shiftEn;
   assign bus4.sop     = bus.sop;
   assign bus4.eop     = bus.eop;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_done = 0;
   bit         pkt[$];
   logic [7:0] dat[$];

   always @(negedge clk) if (bus.done === 1'b1) n_done++;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Generator polynomial 0x8005, MSB-first long division
   function automatic logic [15:0] crc_of(input int nbits);
      logic [15:0] s = 16'hFFFF;
      for (int i = 0; i < nbits; i++) begin
         s = {s[14:0], 1'b0} ^ (((pkt[i] ^ s[15]) != 1'b0) ? 16'h8005 : 16'h0000);
      end
      return s;
   endfunction

   function automatic exp_t model(input int maxb);
      exp_t e;
      int   n = pkt.size();
      e.bytes = 11'((n / 8 > 2047) ? 2047 : n / 8);
      e.err   = (crc_of(n) != 16'h800D);
      e.sh    = (n < 16);
      e.al    = ((n % 8) != 0);
      e.ov    = ((n / 8) > maxb);
      e.ok    = !e.err && !e.sh && !e.al && !e.ov;
      return e;
   endfunction

   task automatic build_good();
      logic [15:0] c;
      pkt = {};
      foreach (dat[i]) for (int b = 0; b < 8; b++) pkt.push_back(dat[i][b]);
      c = crc_of(pkt.size());
      for (int b = 15; b >= 0; b--) pkt.push_back(~c[b]);
   endtask

   task automatic send(input int nbits, input bit sop_first, input bit eop_last,
                       input bit eop_at_sop, input bit do_eop);
      int idx = 0;
      bit eop_sent = 1'b0;
      bus.sop = 1'b1;
      bus.eop = eop_at_sop;
      if (sop_first && nbits > 0) begin
         bus.shiftEn = 1'b1;
         bus.din     = pkt[0];
         idx         = 1;
      end else begin
         bus.shiftEn = 1'b0;
      end
      tick();
      bus.sop = 1'b0;
      bus.eop = 1'b0;
      chk_eq("busy_after_sop", {31'd0, bus.busy}, 32'd1);
      while (idx < nbits) begin
         if ($urandom_range(0, 3) == 0) begin
            bus.shiftEn = 1'b0;
            bus.din     = 1'($urandom);
            tick();
         end
         bus.shiftEn = 1'b1;
         bus.din     = pkt[idx];
         if (do_eop && eop_last && idx == nbits - 1) begin
            bus.eop  = 1'b1;
            eop_sent = 1'b1;
         end
         tick();
         bus.eop = 1'b0;
         idx++;
      end
      bus.shiftEn = 1'b0;
      if (do_eop && !eop_sent) begin
         bus.eop = 1'b1;
         tick();
         bus.eop = 1'b0;
      end
   endtask

   task automatic chk_one(input string tag, input exp_t e, input logic done,
                          input logic busy, input logic [10:0] bc, input logic ok,
                          input logic err, input logic sh, input logic al, input logic ov,
                          input logic exp_done);
      chk_eq({tag, ".done"},  {31'd0, done}, {31'd0, exp_done});
      chk_eq({tag, ".busy"},  {31'd0, busy}, 32'd0);
      chk_eq({tag, ".bytes"}, {21'd0, bc},   {21'd0, e.bytes});
      chk_eq({tag, ".ok"},    {31'd0, ok},   {31'd0, e.ok});
      chk_eq({tag, ".err"},   {31'd0, err},  {31'd0, e.err});
      chk_eq({tag, ".short"}, {31'd0, sh},   {31'd0, e.sh});
      chk_eq({tag, ".align"}, {31'd0, al},   {31'd0, e.al});
      chk_eq({tag, ".ovf"},   {31'd0, ov},   {31'd0, e.ov});
   endtask

   task automatic chk_status(input string tag, input logic exp_done);
      exp_t e;
      exp_t e4;
      e  = model(1026);
      e4 = model(4);
      chk_one({tag, "/d"}, e, bus.done, bus.busy, bus.byte_count, bus.crc_ok,
              bus.crc_err, bus.err_short, bus.err_align, bus.err_ovf, exp_done);
      chk_one({tag, "/d4"}, e4, bus4.done, bus4.busy, bus4.byte_count, bus4.crc_ok,
              bus4.crc_err, bus4.err_short, bus4.err_align, bus4.err_ovf, exp_done);
   endtask

   // Full packet, then the cycle after done: pulse gone, status held
   task automatic run_pkt(input string tag);
      send(pkt.size(), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
      chk_status(tag, 1'b1);
      tick();
      chk_status({tag, "+1"}, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      logic [31:0] v;
      v = {19'd0, bus.byte_count, bus.busy, bus.done, bus.crc_ok,
           bus.crc_err, bus.err_short, bus.err_align, bus.err_ovf};
      chk_eq({tag, "/d"}, v, 32'd0);
      v = {19'd0, bus4.byte_count, bus4.busy, bus4.done, bus4.crc_ok,
           bus4.crc_err, bus4.err_short, bus4.err_align, bus4.err_ovf};
      chk_eq({tag, "/d4"}, v, 32'd0);
   endtask

   initial begin
      int d0;
      int mode;
      bus.din     = 1'b0;
      bus.shiftEn = 1'b0;
      bus.sop     = 1'b0;
      bus.eop     = 1'b0;
      repeat (3) tick();
      chk_zero("in_reset");
      nRst = 1'b1;
      tick();
      chk_zero("after_reset");

      // Zero-length packet and its single-bit corruption
      pkt = {};
      for (int i = 0; i < 16; i++) pkt.push_back(1'b0);
      run_pkt("zlp");
      chk_eq("zlp.ok_const", {31'd0, bus.crc_ok}, 32'd1);
      chk_eq("zlp.bc_const", {21'd0, bus.byte_count}, 32'd2);
      pkt[5] = 1'b1;
      run_pkt("zlp_bit5");
      chk_eq("zlp_bit5.err_const", {31'd0, bus.crc_err}, 32'd1);

      pkt = {};
      for (int i = 0; i < 12; i++) pkt.push_back(1'($urandom));
      run_pkt("bits12");
      chk_eq("bits12.short_const", {31'd0, bus.err_short}, 32'd1);
      pkt = {};
      for (int i = 0; i < 20; i++) pkt.push_back(1'($urandom));
      run_pkt("bits20");
      chk_eq("bits20.align_const", {31'd0, bus.err_align}, 32'd1);

      // Abort after 10 bits, restart with sop+eop together: exactly one done
      dat = {8'h00, 8'h01, 8'h02, 8'h03};
      build_good();
      d0 = n_done;
      send(10, 1'b1, 1'b0, 1'b0, 1'b0);
      send(pkt.size(), 1'b0, 1'b1, 1'b1, 1'b1);
      chk_status("restart", 1'b1);
      chk_eq("restart.ok_const", {31'd0, bus.crc_ok}, 32'd1);
      chk_eq("restart.bc_const", {21'd0, bus.byte_count}, 32'd6);
      chk_eq("ovf4.ov_const", {31'd0, bus4.err_ovf}, 32'd1);
      chk_eq("ovf4.ok_const", {31'd0, bus4.crc_ok}, 32'd0);
      tick();
      tick();
      chk_eq("restart.done_count", n_done - d0, 32'd1);

      // Reset in the middle of a packet
      d0 = n_done;
      send(20, 1'b1, 1'b0, 1'b0, 1'b0);
      nRst = 1'b0;
      #1;
      chk_zero("mid_reset");
      tick();
      tick();
      nRst = 1'b1;
      tick();
      chk_zero("post_mid_reset");
      chk_eq("mid_reset.no_done", n_done - d0, 32'd0);

      // Randomized packets with corruption, truncation, extension and idle noise
      for (int p = 0; p < 30; p++) begin
         dat = {};
         for (int i = 0; i < $urandom_range(0, 8); i++) dat.push_back(8'($urandom));
         build_good();
         mode = $urandom_range(0, 3);
         if (mode == 1) begin
            d0 = $urandom_range(0, pkt.size() - 1);
            pkt[d0] = ~pkt[d0];
         end else if (mode == 2) begin
            for (int i = 0; i < $urandom_range(1, 7); i++) void'(pkt.pop_back());
         end else if (mode == 3) begin
            for (int i = 0; i < $urandom_range(1, 9); i++) pkt.push_back(1'($urandom));
         end
         run_pkt($sformatf("rnd%0d", p));
         bus.eop     = 1'b1;
         bus.shiftEn = 1'b1;
         bus.din     = 1'($urandom);
         tick();
         tick();
         bus.eop     = 1'b0;
         bus.shiftEn = 1'b0;
         chk_status($sformatf("idle%0d", p), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
